// File: rtl/cnn_pkg.sv
// Shared constants, FSM encoding and activation helpers for the CNN datapath layers.
package cnn_pkg;

  localparam int M     = 4;
  localparam int N     = 16;
  localparam int W     = 8;
  localparam int ACC_W = 2 * W + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (W - 1)) - 1);

  function automatic logic signed [ACC_W-1:0] sext(input logic signed [W-1:0] x);
    return {{(ACC_W - W){x[W-1]}}, x};
  endfunction

  // ReLU followed by clamp to the largest positive W-bit value
  function automatic logic [W-1:0] relu_sat(input logic signed [ACC_W-1:0] s);
    logic [W-1:0] r;
    if (s[ACC_W-1]) begin
      r = {W{1'b0}};
    end else if (s > SAT_MAX) begin
      r = {1'b0, {(W - 1){1'b1}}};
    end else begin
      r = s[W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/mac3.sv
// Registered three-tap signed multiply-accumulate with bias; one result per clock.
import cnn_pkg::*;

module mac3 (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [W-1:0]     d1,
  input  logic signed [W-1:0]     d2,
  input  logic signed [W-1:0]     d3,
  input  logic signed [W-1:0]     w0,
  input  logic signed [W-1:0]     w1,
  input  logic signed [W-1:0]     w2,
  input  logic signed [W-1:0]     bias,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [ACC_W-1:0] sum_s;
  logic signed [ACC_W-1:0] acc_r;

  // operands widened first so every product and the sum stay exact
  always_comb begin
    sum_s = sext(w0) * sext(d1) + sext(w1) * sext(d2) + sext(w2) * sext(d3) + sext(bias);
  end

  // accumulator register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= {ACC_W{1'b0}};
    end else begin
      acc_r <= sum_s;
    end
  end

  assign acc = acc_r;

endmodule

// File: rtl/conv3_engine.sv
// Three-tap 1-D convolution engine: issues register-file reads, runs MAC, shift,
// ReLU and saturation, and streams one activation per cycle.
import cnn_pkg::*;

module conv3_engine #(
  parameter int SHIFT = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                Start,
  input  logic [M-1:0]        BaseAddr,
  input  logic [M-1:0]        NumOut,
  input  logic signed [W-1:0] Wt0,
  input  logic signed [W-1:0] Wt1,
  input  logic signed [W-1:0] Wt2,
  input  logic signed [W-1:0] Bias,
  output logic                ReadEn,
  output logic [M-1:0]        ReadReg1,
  output logic [M-1:0]        ReadReg2,
  output logic [M-1:0]        ReadReg3,
  input  logic signed [W-1:0] ReadData1,
  input  logic signed [W-1:0] ReadData2,
  input  logic signed [W-1:0] ReadData3,
  output logic                OutValid,
  output logic [W-1:0]        OutData,
  output logic [M-1:0]        OutIndex,
  output logic                Busy,
  output logic                Done
);

  state_t state_r, state_s;
  logic [M-1:0] num_r, cnt_r, rr1_r, rr2_r, rr3_r, idx1_r, idx2_r, oi_r;
  logic signed [W-1:0] w0_r, w1_r, w2_r, bias_r;
  logic re_r, vld1_r, vld2_r, ov_r, busy_r, done_r;
  logic [W-1:0] od_r;
  logic signed [ACC_W-1:0] acc_s, shifted_s;
  logic last_issue_s, last_out_s;

  assign last_issue_s = (cnt_r == num_r - M'(1));
  assign last_out_s   = vld2_r && (idx2_r == num_r - M'(1));
  assign shifted_s    = acc_s >>> SHIFT;

  // next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (Start) begin
          state_s = (NumOut == M'(0)) ? DONE : ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (last_issue_s) begin
          state_s = DRAIN;
        end else begin
          state_s = ISSUE;
        end
      end
      DRAIN: begin
        if (last_out_s) begin
          state_s = DONE;
        end else begin
          state_s = DRAIN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // control registers: state, latched job parameters, address counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      re_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      num_r   <= {M{1'b0}};
      cnt_r   <= {M{1'b0}};
      rr1_r   <= {M{1'b0}};
      rr2_r   <= {M{1'b0}};
      rr3_r   <= {M{1'b0}};
      w0_r    <= {W{1'b0}};
      w1_r    <= {W{1'b0}};
      w2_r    <= {W{1'b0}};
      bias_r  <= {W{1'b0}};
    end else begin
      state_r <= state_s;
      re_r    <= (state_s == ISSUE);
      busy_r  <= (state_s != IDLE);
      done_r  <= (state_s == DONE);
      if (state_r == IDLE && Start) begin
        num_r  <= NumOut;
        w0_r   <= Wt0;
        w1_r   <= Wt1;
        w2_r   <= Wt2;
        bias_r <= Bias;
        cnt_r  <= {M{1'b0}};
        // addresses only move when a window is really issued
        if (NumOut != M'(0)) begin
          rr1_r <= BaseAddr;
          rr2_r <= BaseAddr + M'(1);
          rr3_r <= BaseAddr + M'(2);
        end
      end else if (state_r == ISSUE && !last_issue_s) begin
        cnt_r <= cnt_r + M'(1);
        rr1_r <= rr1_r + M'(1);
        rr2_r <= rr2_r + M'(1);
        rr3_r <= rr3_r + M'(1);
      end
    end
  end

  mac3 u_mac3 (
    .clk  (clk),
    .rst_n(rst_n),
    .d1   (ReadData1),
    .d2   (ReadData2),
    .d3   (ReadData3),
    .w0   (w0_r),
    .w1   (w1_r),
    .w2   (w2_r),
    .bias (bias_r),
    .acc  (acc_s)
  );

  // valid/index pipeline aligned with read data, MAC and output stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld1_r <= 1'b0;
      vld2_r <= 1'b0;
      idx1_r <= {M{1'b0}};
      idx2_r <= {M{1'b0}};
      ov_r   <= 1'b0;
      od_r   <= {W{1'b0}};
      oi_r   <= {M{1'b0}};
    end else begin
      vld1_r <= re_r;
      idx1_r <= cnt_r;
      vld2_r <= vld1_r;
      idx2_r <= idx1_r;
      ov_r   <= vld2_r;
      if (vld2_r) begin
        od_r <= relu_sat(shifted_s);
        oi_r <= idx2_r;
      end
    end
  end

  assign ReadEn   = re_r;
  assign ReadReg1 = rr1_r;
  assign ReadReg2 = rr2_r;
  assign ReadReg3 = rr3_r;
  assign OutValid = ov_r;
  assign OutData  = od_r;
  assign OutIndex = oi_r;
  assign Busy     = busy_r;
  assign Done     = done_r;

endmodule

// File: tb/tb_conv3_engine.sv
// Directed self-checking bench for conv3_engine with a behavioural register file.
module tb_conv3_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start_req;
  logic sel;
  logic [3:0] base, num;
  logic signed [7:0] wt0, wt1, wt2, bias;
  logic signed [7:0] mem [16];

  logic [1:0] st, re, ov, busy, done;
  logic [1:0][3:0] rr1, rr2, rr3, oidx;
  logic [1:0][7:0] rd1 = '0, rd2 = '0, rd3 = '0, odat;

  int n_checks = 0;
  int n_fail = 0;
  int exp_q[$];

  assign st = {start_req && sel, start_req && !sel};

  conv3_engine #(.SHIFT(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .Start(st[0]), .BaseAddr(base), .NumOut(num),
    .Wt0(wt0), .Wt1(wt1), .Wt2(wt2), .Bias(bias),
    .ReadEn(re[0]), .ReadReg1(rr1[0]), .ReadReg2(rr2[0]), .ReadReg3(rr3[0]),
    .ReadData1(rd1[0]), .ReadData2(rd2[0]), .ReadData3(rd3[0]),
    .OutValid(ov[0]), .OutData(odat[0]), .OutIndex(oidx[0]), .Busy(busy[0]), .Done(done[0])
  );

  conv3_engine #(.SHIFT(2)) u_dut_sh (
    .clk(clk), .rst_n(rst_n), .Start(st[1]), .BaseAddr(base), .NumOut(num),
    .Wt0(wt0), .Wt1(wt1), .Wt2(wt2), .Bias(bias),
    .ReadEn(re[1]), .ReadReg1(rr1[1]), .ReadReg2(rr2[1]), .ReadReg3(rr3[1]),
    .ReadData1(rd1[1]), .ReadData2(rd2[1]), .ReadData3(rd3[1]),
    .OutValid(ov[1]), .OutData(odat[1]), .OutIndex(oidx[1]), .Busy(busy[1]), .Done(done[1])
  );

  // registered three-port read, one copy per engine
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (re[k]) begin
        rd1[k] <= mem[rr1[k]];
        rd2[k] <= mem[rr2[k]];
        rd3[k] <= mem[rr3[k]];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " ReadEn"}, 32'(re[sel]), 32'd0);
    chk({tag, " ReadReg1"}, 32'(rr1[sel]), 32'd0);
    chk({tag, " ReadReg2"}, 32'(rr2[sel]), 32'd0);
    chk({tag, " ReadReg3"}, 32'(rr3[sel]), 32'd0);
    chk({tag, " OutValid"}, 32'(ov[sel]), 32'd0);
    chk({tag, " OutData"}, 32'(odat[sel]), 32'd0);
    chk({tag, " OutIndex"}, 32'(oidx[sel]), 32'd0);
    chk({tag, " Busy"}, 32'(busy[sel]), 32'd0);
    chk({tag, " Done"}, 32'(done[sel]), 32'd0);
  endtask

  task automatic set_mem_ramp();
    for (int k = 0; k < 16; k++) mem[k] = 8'(k);
  endtask

  task automatic set_mem_const(input logic signed [7:0] v);
    for (int k = 0; k < 16; k++) mem[k] = v;
  endtask

  // one job; expectations follow the cycle-accurate schedule relative to Start cycle s
  task automatic run(input string tag, input logic s, input logic [3:0] b, input int n, input bit poke);
    logic busy_e, done_e, re_e, ov_e;
    sel = s;
    base = b;
    num = 4'(n);
    start_req = 1'b1;
    @(negedge clk);
    start_req = 1'b0;
    for (int c = 1; c <= n + 6; c++) begin
      busy_e = (n == 0) ? (c == 1) : (c <= n + 3);
      done_e = (n == 0) ? (c == 1) : (c == n + 3);
      re_e   = (n != 0) && (c <= n);
      ov_e   = (n != 0) && (c >= 4) && (c <= n + 3);
      chk($sformatf("%s busy c%0d", tag, c), 32'(busy[sel]), 32'(busy_e));
      chk($sformatf("%s done c%0d", tag, c), 32'(done[sel]), 32'(done_e));
      chk($sformatf("%s rden c%0d", tag, c), 32'(re[sel]), 32'(re_e));
      chk($sformatf("%s oval c%0d", tag, c), 32'(ov[sel]), 32'(ov_e));
      if (re_e) begin
        chk($sformatf("%s rreg1 c%0d", tag, c), 32'(rr1[sel]), 32'((b + c - 1) % 16));
        chk($sformatf("%s rreg2 c%0d", tag, c), 32'(rr2[sel]), 32'((b + c) % 16));
        chk($sformatf("%s rreg3 c%0d", tag, c), 32'(rr3[sel]), 32'((b + c + 1) % 16));
      end
      if (ov_e) begin
        chk($sformatf("%s oidx c%0d", tag, c), 32'(oidx[sel]), 32'(c - 4));
        chk($sformatf("%s odat c%0d", tag, c), 32'(odat[sel]), 32'(exp_q[c - 4]));
      end
      start_req = 1'b0;
      if (poke && (c == 2 || c == n + 3)) begin
        start_req = 1'b1;
        base = 4'd9;
        num = 4'd2;
        wt0 = 8'sd5;
        wt1 = 8'sd5;
        wt2 = 8'sd5;
        bias = 8'sd50;
      end
      @(negedge clk);
    end
    start_req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start_req = 1'b0;
    sel = 1'b0;
    base = 4'd0;
    num = 4'd0;
    {wt0, wt1, wt2, bias} = 32'd0;
    set_mem_ramp();
    @(negedge clk);
    @(negedge clk);
    chk_zero("rst0");
    sel = 1'b1;
    chk_zero("rst1");
    rst_n = 1'b1;
    @(negedge clk);

    // ramp, unit weights: 3j+3
    wt0 = 8'sd1; wt1 = 8'sd1; wt2 = 8'sd1; bias = 8'sd0;
    exp_q = {};
    for (int j = 0; j < 14; j++) exp_q.push_back(3 * j + 3);
    run("ramp", 1'b0, 4'd0, 14, 1'b0);

    // saturation and ReLU
    set_mem_const(8'sd127);
    wt0 = 8'sd127; wt1 = 8'sd127; wt2 = 8'sd127; bias = 8'sd127;
    exp_q = '{127, 127};
    run("sat", 1'b0, 4'd3, 2, 1'b0);
    wt0 = -8'sd1; wt1 = -8'sd1; wt2 = -8'sd1; bias = 8'sd0;
    exp_q = '{0, 0};
    run("relu", 1'b0, 4'd5, 2, 1'b0);

    // address wrap
    set_mem_ramp();
    wt0 = 8'sd1; wt1 = 8'sd0; wt2 = 8'sd0; bias = 8'sd0;
    exp_q = '{14, 15, 0};
    run("wrap", 1'b0, 4'd14, 3, 1'b0);

    // shift by 2: (300+4)>>>2 = 76, -300>>>2 = -75 -> 0
    set_mem_const(8'sd100);
    wt0 = 8'sd1; wt1 = 8'sd1; wt2 = 8'sd1; bias = 8'sd4;
    exp_q = '{76, 76};
    run("shift", 1'b1, 4'd0, 2, 1'b0);
    set_mem_const(-8'sd100);
    bias = 8'sd0;
    exp_q = '{0, 0};
    run("shneg", 1'b1, 4'd0, 2, 1'b0);

    // empty job, then Start/input changes while busy
    set_mem_ramp();
    exp_q = {};
    run("empty", 1'b0, 4'd6, 0, 1'b0);
    wt0 = 8'sd1; wt1 = 8'sd1; wt2 = 8'sd1; bias = 8'sd0;
    exp_q = '{9, 12, 15};
    run("busy", 1'b0, 4'd2, 3, 1'b1);

    // reset in the middle of a run
    sel = 1'b0;
    wt0 = 8'sd1; wt1 = 8'sd1; wt2 = 8'sd1; bias = 8'sd0;
    base = 4'd0;
    num = 4'd14;
    start_req = 1'b1;
    @(negedge clk);
    start_req = 1'b0;
    for (int c = 1; c < 5; c++) @(negedge clk);
    chk("pre-rst oval", 32'(ov[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      chk($sformatf("postrst quiet %0d", c), 32'({ov[0], done[0], busy[0]}), 32'd0);
      @(negedge clk);
    end
    exp_q = {};
    for (int j = 0; j < 14; j++) exp_q.push_back(3 * j + 3);
    run("rerun", 1'b0, 4'd0, 14, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
